// File: rtl/intersection_sequencer_if.sv
// Purpose: request inputs, lamp outputs and state observation port of the
//          two-approach intersection sequencer.
// Ports:
//   CarA, CarB, Ped                      - sensor and button inputs, driven by the master side
//   SigGA/SigYA/SigRA, SigGB/SigYB/SigRB - approach lamps, driven by the sequencer
//   Walk, PedPending                     - walk lamp and latched pedestrian request
//   State                                - current sequencer state
interface intersection_sequencer_if;
    logic       CarA;
    logic       CarB;
    logic       Ped;
    logic       SigGA;
    logic       SigYA;
    logic       SigRA;
    logic       SigGB;
    logic       SigYB;
    logic       SigRB;
    logic       Walk;
    logic       PedPending;
    logic [2:0] State;

    // Environment side: drives the requests and observes the lamps.
    modport master (
        output CarA, CarB, Ped,
        input  SigGA, SigYA, SigRA, SigGB, SigYB, SigRB, Walk, PedPending, State
    );

    // Sequencer side: consumes the requests and drives the lamps.
    modport slave (
        input  CarA, CarB, Ped,
        output SigGA, SigYA, SigRA, SigGB, SigYB, SigRB, Walk, PedPending, State
    );
endinterface

// File: rtl/intersection_sequencer.sv
// Purpose: sequences green/yellow/all-red phases for two conflicting approaches
//          plus a pedestrian walk phase. It latches the car and pedestrian
//          requests and times each phase with a saturating dwell counter.
// Ports:
//   CLK  - clock; all state changes happen on the rising edge
//   RST  - asynchronous, active-high reset
//   bus  - slave modport: CarA/CarB/Ped in; lamps, Walk, PedPending and State out
module intersection_sequencer #(
    parameter int unsigned CW        = 5,
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 16,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 6
) (
    input  logic                    CLK,
    input  logic                    RST,
    intersection_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_AG  = 3'd0,
        S_AY  = 3'd1,
        S_ARB = 3'd2,
        S_BG  = 3'd3,
        S_BY  = 3'd4,
        S_ARA = 3'd5,
        S_WK  = 3'd6
    } state_e;

    // Last-phase thresholds: a phase of length N ends when cnt reaches N-1.
    localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_LAST   = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] WK_LAST   = CW'(WALK_T - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    // Lamp vector order: {GA, YA, RA, GB, YB, RB, Walk}
    localparam logic [6:0] LAMP_RESET = 7'b100_001_0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          req_a_q, req_a_d;
    logic          req_b_q, req_b_d;
    logic          ped_q,   ped_d;
    logic          last_b_q, last_b_d;   // 0: A was the last green, 1: B
    logic [6:0]    lamp_q,  lamp_d;

    logic          trans;
    logic          enter_ag;
    logic          enter_bg;
    logic          enter_wk;

    // Moore lamp decode; each approach always shows exactly one lamp.
    function automatic logic [6:0] lamps_of(state_e s);
        logic [6:0] l;
        l = 7'b001_001_0;
        case (s)
            S_AG:    l = 7'b100_001_0;
            S_AY:    l = 7'b010_001_0;
            S_BG:    l = 7'b001_100_0;
            S_BY:    l = 7'b001_010_0;
            S_WK:    l = 7'b001_001_1;
            default: l = 7'b001_001_0;
        endcase
        return l;
    endfunction

    // Next state, dwell counter, request latches and registered lamps.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;

        case (state_q)
            S_AG: begin
                if (cnt_q >= GMIN_LAST && (req_b_q || ped_q) &&
                    (!bus.CarA || cnt_q >= GMAX_LAST))
                    state_d = S_AY;
            end
            S_AY: begin
                if (cnt_q >= Y_LAST) begin
                    state_d  = S_ARB;
                    last_b_d = 1'b0;
                end
            end
            S_ARB: begin
                if (cnt_q >= AR_LAST)
                    state_d = ped_q ? S_WK : S_BG;
            end
            S_BG: begin
                if (cnt_q >= GMIN_LAST && (req_a_q || ped_q) &&
                    (!bus.CarB || cnt_q >= GMAX_LAST))
                    state_d = S_BY;
            end
            S_BY: begin
                if (cnt_q >= Y_LAST) begin
                    state_d  = S_ARA;
                    last_b_d = 1'b1;
                end
            end
            S_ARA: begin
                if (cnt_q >= AR_LAST)
                    state_d = ped_q ? S_WK : S_AG;
            end
            S_WK: begin
                // Serve the approach that did not hold green before the walk.
                if (cnt_q >= WK_LAST)
                    state_d = last_b_q ? S_AG : S_BG;
            end
            default: state_d = S_AG;
        endcase

        trans    = (state_d != state_q);
        enter_ag = trans && (state_d == S_AG);
        enter_bg = trans && (state_d == S_BG);
        enter_wk = trans && (state_d == S_WK);

        if (trans)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);

        // A press is latched until its phase is entered; presses during the walk are dropped.
        req_a_d = (req_a_q || bus.CarA) && !enter_ag;
        req_b_d = (req_b_q || bus.CarB) && !enter_bg;
        ped_d   = (ped_q || (bus.Ped && state_q != S_WK)) && !enter_wk;

        lamp_d  = lamps_of(state_d);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_AG;
            cnt_q    <= '0;
            req_a_q  <= 1'b0;
            req_b_q  <= 1'b0;
            ped_q    <= 1'b0;
            last_b_q <= 1'b0;
            lamp_q   <= LAMP_RESET;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_a_q  <= req_a_d;
            req_b_q  <= req_b_d;
            ped_q    <= ped_d;
            last_b_q <= last_b_d;
            lamp_q   <= lamp_d;
        end
    end

    assign bus.SigGA      = lamp_q[6];
    assign bus.SigYA      = lamp_q[5];
    assign bus.SigRA      = lamp_q[4];
    assign bus.SigGB      = lamp_q[3];
    assign bus.SigYB      = lamp_q[2];
    assign bus.SigRB      = lamp_q[1];
    assign bus.Walk       = lamp_q[0];
    assign bus.PedPending = ped_q;
    assign bus.State      = 3'(state_q);

endmodule
